// File: rtl/ttl_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ttl_dispatch_pkg
// Description : Shared types and event field layout for the TTL event
//               dispatcher (FSM state encoding, event struct, field bounds).
// Revision    : 1.0 - initial release
// ============================================================================
package ttl_dispatch_pkg;

  // Dispatcher control states; encoding is exposed on the status port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Event field bounds inside the 128-bit event word.
  localparam int TS_MSB      = 127;
  localparam int TS_LSB      = 64;
  localparam int PAYLOAD_MSB = 63;

  // Timestamped event: timestamp in the upper half, payload in the lower.
  typedef struct packed {
    logic [TS_MSB-TS_LSB:0] ts;
    logic [PAYLOAD_MSB:0]   payload;
  } event_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Single-clock first-word-fall-through FIFO. The head entry is
//               presented on dout whenever the FIFO is not empty. Writes when
//               full are dropped, even if a read happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                AW      = $clog2(DEPTH);
  localparam logic [AW:0]       C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_wr  = wr_en && !full;
  assign w_rd  = rd_en && !empty;
  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally for power-of-two depth.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ttl_event_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : ttl_event_dispatcher
// Description : Buffers timestamped events and owns the 64-bit timeline
//               counter. Issues the head event for one cycle when the counter
//               equals its timestamp; drops and reports events already past.
// Revision    : 1.0 - initial release
// ============================================================================
module ttl_event_dispatcher
  import ttl_dispatch_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TS_WIDTH   = 64
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [127:0]                  in_data,
  input  logic                          counter_start,
  input  logic                          counter_stop,
  input  logic                          counter_clear,
  input  logic                          flush,
  output logic [TS_WIDTH-1:0]           counter_value,
  output logic [127:0]                  gpo_out,
  output logic                          counter_matched,
  output logic                          late_error,
  output logic [127:0]                  late_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e          r_state;
  logic [TS_WIDTH-1:0] r_counter;
  logic            r_matched;
  logic            r_late;
  event_t          r_gpo;
  event_t          r_late_data;

  logic [127:0]    w_fifo_dout;
  event_t          w_head;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_fifo_count;
  logic            w_wr_en;
  logic            w_rd_en;
  logic            w_match;
  logic            w_late;
  logic            w_last_entry;

  assign w_head       = event_t'(w_fifo_dout);
  assign in_ready     = !w_full && (r_state != FLUSH);
  assign w_wr_en      = in_valid && in_ready;
  assign w_last_entry = w_empty || (w_fifo_count == CW'(1));

  sync_fifo_fwft #(
    .WIDTH (128),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .wr_en  (w_wr_en),
    .din    (in_data),
    .rd_en  (w_rd_en),
    .dout   (w_fifo_dout),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_fifo_count)
  );

  // Head compare against the live counter; pop on match, late, or flush drain.
  always_comb begin
    w_match = 1'b0;
    w_late  = 1'b0;
    w_rd_en = 1'b0;
    if (r_state == RUN && !w_empty) begin
      w_match = (w_head.ts == r_counter);
      w_late  = (w_head.ts <  r_counter);
      w_rd_en = w_match || w_late;
    end else if (r_state == FLUSH) begin
      w_rd_en = !w_empty;
    end
  end

  // Control FSM and timeline counter; clear overrides the RUN increment.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_counter <= '0;
    end else begin
      if (counter_clear) begin
        r_counter <= '0;
      end else if (r_state == RUN) begin
        r_counter <= r_counter + 1'b1;
      end

      if (flush) begin
        r_state <= FLUSH;
      end else begin
        case (r_state)
          IDLE:    if (counter_start) r_state <= RUN;
          RUN:     if (counter_stop)  r_state <= IDLE;
          FLUSH:   if (w_last_entry)  r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Registered dispatch/late strobes; data outputs hold between events.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_matched   <= 1'b0;
      r_late      <= 1'b0;
      r_gpo       <= '0;
      r_late_data <= '0;
    end else begin
      r_matched <= w_match;
      r_late    <= w_late;
      if (w_match) r_gpo       <= w_head;
      if (w_late)  r_late_data <= w_head;
    end
  end

  assign counter_value   = r_counter;
  assign gpo_out         = r_gpo;
  assign counter_matched = r_matched;
  assign late_error      = r_late;
  assign late_data       = r_late_data;
  assign fifo_count      = w_fifo_count;
  assign state           = r_state;

endmodule
`default_nettype wire

// File: doc/ttl_event_dispatcher.md
Name: ttl_event_dispatcher

Overview:
- Upstream stage of the TTL output channel.
- Buffers 128-bit timestamped events written by the host/RTIO bus and owns a 64-bit timeline counter.
- When the counter reaches the timestamp of the head event, issues it for one cycle on gpo_out/counter_matched. These outputs feed the GPO_Core gpo_in/counter_matched inputs of a TTL output channel.
- Events whose time has already passed are dropped and reported.

Parameters:
- FIFO_DEPTH, 16, event buffer depth in entries; power of two, at least 2.
- TS_WIDTH, 64, timestamp/counter width; event bits [127:64] carry the timestamp.

Ports:
- clk  in  1  system clock; same clk that drives the TTL output channel.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  event write request.
- in_ready  out  1  buffer can accept an event.
- in_data  in  128  event: [127:64] timestamp, [63:0] payload (payload [7:0] is the 8-sample TTL pattern).
- counter_start  in  1  pulse: begin counting (IDLE to RUN).
- counter_stop  in  1  pulse: stop counting (RUN to IDLE); counter holds its value.
- counter_clear  in  1  pulse: counter set to 0.
- flush  in  1  pulse: discard all buffered events.
- counter_value  out  64  current timeline counter.
- gpo_out  out  128  dispatched event; drives the channel gpo_in.
- counter_matched  out  1  one-cycle dispatch strobe.
- late_error  out  1  one-cycle strobe: head event was in the past and was dropped.
- late_data  out  128  dropped event, held until the next drop.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- state  out  2  FSM state, for debug/status.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE, counter_value=0, FIFO emptied.
  - gpo_out=0, counter_matched=0, late_error=0, late_data=0, fifo_count=0.
  - in_ready=1 from the first cycle after reset is released.
  - Reset mid-operation discards all events silently; no late_error is raised.
- FSM states: IDLE=0, RUN=1, FLUSH=2.
  - IDLE: counter holds; no dispatch and no late checks. counter_start moves to RUN.
  - RUN: counter increments by 1 per cycle, wrapping at 2^64 to 0. counter_stop moves to IDLE.
  - FLUSH: entered from any state on flush. Counter holds, in_ready=0, one entry popped per cycle with no strobes. When the FIFO is empty, return to IDLE.
  - Priority: flush > counter_stop > counter_start.
- counter_clear:
  - Applies in any state and takes priority over the increment; the counter is 0 on the next cycle.
  - clear together with start: counter 0 and state RUN on the next cycle; the first increment happens one cycle later.
- FIFO:
  - First-word-fall-through; the head is visible combinationally.
  - Write when in_valid && in_ready, with in_ready = !full && state!=FLUSH.
  - No write bypass when full, even if a pop occurs in the same cycle.
  - Writes in IDLE are accepted.
- Dispatch (RUN only, head valid; unsigned compare of head timestamp with counter_value in cycle t):
  - Equal: pop in cycle t. In t+1, counter_matched=1 and gpo_out=the popped event (registered, latency 1).
  - Head timestamp < counter_value: pop in t. In t+1, late_error=1 and late_data=the event.
  - Greater: nothing happens.
- Dispatch timing consequences:
  - Back-to-back timestamps (T, T+1) dispatch on consecutive cycles.
  - A duplicate timestamp T,T dispatches the first event and reports the second as late.
- gpo_out holds its last value when counter_matched=0.
- counter_matched and late_error are never both 1 in the same cycle.
- Wrap-around: timestamps are compared as plain unsigned values. After the counter wraps, older large timestamps appear in the future; this is accepted behaviour, not an error.

Decomposition:
- Package ttl_dispatch_pkg:
  - state enum {IDLE, RUN, FLUSH};
  - event field constants TS_MSB=127, TS_LSB=64, PAYLOAD_MSB=63;
  - event_t packed struct {ts, payload}.
- Sub-module: sync_fifo_fwft (WIDTH, DEPTH, signals wr_en/rd_en/dout/full/empty/count, active-low synchronous reset).
- Counter, FSM and compare/dispatch logic stay in the top level.

Test Plan:
- Reset, write event ts=10, payload=0xA5, clear+start in the same cycle → counter_matched=1 with gpo_out[63:0]=0xA5 in the cycle after counter_value==10; fifo_count returns to 0.
- Write ts=20,21,22, then start → three consecutive counter_matched pulses carrying the payloads in order; no late_error.
- Run the counter to 50, then write ts=30 → late_error pulse within 2 cycles, late_data[127:64]=30, no counter_matched.
- Write events ts=5 and ts=5 → the first dispatches, the second raises late_error with late_data[127:64]=5.
- Write FIFO_DEPTH events with no start → in_ready=0, fifo_count=16, an extra write is ignored. flush → state=FLUSH for 16 cycles, then IDLE, fifo_count=0, no strobes.
- Mid-RUN with 3 events pending, assert resetn=0 for one cycle → all outputs at reset values, counter 0, state IDLE, fifo_count=0.
